// File: rtl/battle_pkg.sv
// Shared types and constants for the battle-grid blocks: grid geometry,
// cell coordinate types, the random-cell FSM states and the LFSR step.
package battle_pkg;

  localparam int GRID_COLS    = 20;
  localparam int GRID_ROWS    = 15;
  localparam int CELL_SIZE_PX = 32;

  typedef logic [4:0] cell_x_t;
  typedef logic [3:0] cell_y_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    LOOKUP,
    CHECK,
    PRESENT
  } rcg_state_t;

  // One step of the 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR; steps on every clock, restarts from SEED on reset.
module lfsr16
  import battle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value.
  always_comb begin
    lfsr_d = lfsr16_next(lfsr_q);
  end

  // LFSR state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/random_cell_gen.sv
// Random grid-cell generator: on request or spawn-period expiry, draws LFSR
// candidates, rejects off-grid or occupied cells via a matrix lookup, and
// presents the first free cell (or a fallback) with a one-clock strobe.
module random_cell_gen
  import battle_pkg::*;
#(
  parameter int          COLS         = GRID_COLS,
  parameter int          ROWS         = GRID_ROWS,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          SPAWN_PERIOD = 10,
  parameter int          MAX_ATTEMPTS = 64,
  parameter int          FALLBACK_X   = 4,
  parameter int          FALLBACK_Y   = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       spawnEn,
  input  logic       newRandom,
  input  logic       cellBlocked,
  output logic [4:0] queryX,
  output logic [3:0] queryY,
  output logic [4:0] outRandomX,
  output logic [3:0] outRandomY,
  output logic       randomRise,
  output logic       busy
);

  localparam cell_x_t FB_X = cell_x_t'(FALLBACK_X);
  localparam cell_y_t FB_Y = cell_y_t'(FALLBACK_Y);

  logic [15:0] lfsr;
  logic        lfsr_unused;
  cell_x_t     cand_x;
  cell_y_t     cand_y;
  logic        cand_in_range;

  rcg_state_t  state_q, state_d;
  logic [3:0]  sec_cnt_q, sec_cnt_d;
  logic [6:0]  attempts_q, attempts_d;
  cell_x_t     query_x_q, query_x_d;
  cell_y_t     query_y_q, query_y_d;
  cell_x_t     out_x_q, out_x_d;
  cell_y_t     out_y_q, out_y_d;

  logic [6:0]  att_inc;
  logic        att_exhausted;
  logic        period_end;
  logic        use_fallback;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .q      (lfsr)
  );

  assign cand_x        = lfsr[4:0];
  assign cand_y        = lfsr[8:5];
  assign lfsr_unused   = ^lfsr[15:9];
  assign cand_in_range = (int'(cand_x) < COLS) && (int'(cand_y) < ROWS);

  // Attempt counter saturates instead of wrapping.
  assign att_inc       = (attempts_q == 7'h7F) ? attempts_q : attempts_q + 7'd1;
  assign att_exhausted = int'(att_inc) >= MAX_ATTEMPTS;
  assign period_end    = one_sec && (int'(sec_cnt_q) == SPAWN_PERIOD - 1);

  // Next-state and datapath updates for the search FSM.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    attempts_d   = attempts_q;
    query_x_d    = query_x_q;
    query_y_d    = query_y_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    use_fallback = 1'b0;

    if (state_q != IDLE && !spawnEn) begin
      // Disable aborts any search in progress without a strobe.
      state_d   = IDLE;
      sec_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!spawnEn) begin
            sec_cnt_d = '0;
          end else if (newRandom || period_end) begin
            sec_cnt_d  = '0;
            attempts_d = '0;
            state_d    = DRAW;
          end else if (one_sec) begin
            sec_cnt_d = sec_cnt_q + 4'd1;
          end
        end
        DRAW: begin
          if (int'(attempts_q) >= MAX_ATTEMPTS) begin
            use_fallback = 1'b1;
          end else if (!cand_in_range) begin
            attempts_d   = att_inc;
            use_fallback = att_exhausted;
          end else begin
            query_x_d = cand_x;
            query_y_d = cand_y;
            state_d   = LOOKUP;
          end
        end
        LOOKUP: begin
          // Matrix read latency: occupancy is valid in the next cycle.
          state_d = CHECK;
        end
        CHECK: begin
          if (!cellBlocked) begin
            out_x_d = query_x_q;
            out_y_d = query_y_q;
            state_d = PRESENT;
          end else begin
            attempts_d   = att_inc;
            use_fallback = att_exhausted;
            state_d      = DRAW;
          end
        end
        PRESENT: begin
          sec_cnt_d = '0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (use_fallback) begin
        out_x_d = FB_X;
        out_y_d = FB_Y;
        state_d = PRESENT;
      end
    end
  end

  // FSM state, counters and coordinate registers.
  // NOTE: asynchronous active-low reset returns every register, including
  // the coordinate outputs, to a known value immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      sec_cnt_q  <= '0;
      attempts_q <= '0;
      query_x_q  <= FB_X;
      query_y_q  <= FB_Y;
      out_x_q    <= FB_X;
      out_y_q    <= FB_Y;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      attempts_q <= attempts_d;
      query_x_q  <= query_x_d;
      query_y_q  <= query_y_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
    end
  end

  assign queryX     = query_x_q;
  assign queryY     = query_y_q;
  assign outRandomX = out_x_q;
  assign outRandomY = out_y_q;
  assign randomRise = (state_q == PRESENT);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_random_cell_gen.sv
// Scoreboard bench for random_cell_gen: stimulus pushes predicted strobes
// (coordinates and cycle) from a golden LFSR and search model; a monitor
// pops and compares on every randomRise.
module tb_random_cell_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       resetN;
  logic       one_sec;
  logic       spawnEn;
  logic       newRandom;
  logic       cellBlocked;
  logic [4:0] queryX;
  logic [3:0] queryY;
  logic [4:0] outRandomX;
  logic [3:0] outRandomY;
  logic       randomRise;
  logic       busy;

  typedef struct {
    logic [4:0] x;
    logic [3:0] y;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          bad_query = 0;
  int          cur_mode = 0;
  int          cur_salt = 0;
  logic [15:0] m_lfsr;
  logic [15:0] draw_l;

  random_cell_gen #(
    .COLS(20), .ROWS(15), .SEED(SEED), .SPAWN_PERIOD(10),
    .MAX_ATTEMPTS(64), .FALLBACK_X(4), .FALLBACK_Y(4)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .one_sec     (one_sec),
    .spawnEn     (spawnEn),
    .newRandom   (newRandom),
    .cellBlocked (cellBlocked),
    .queryX      (queryX),
    .queryY      (queryY),
    .outRandomX  (outRandomX),
    .outRandomY  (outRandomY),
    .randomRise  (randomRise),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] step16(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic bit in_range(input logic [15:0] l);
    return (l[4:0] < 5'd20) && (l[8:5] < 4'd15);
  endfunction

  // Maze occupancy: 0 = all free, 1 = all blocked, else a salted pattern.
  function automatic bit blocked_fn(input logic [4:0] x, input logic [3:0] y,
                                    input int mode, input int salt);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ((int'(x) * 7 + int'(y) * 13 + salt) % 3) == 0;
  endfunction

  // Search outcome from the LFSR value seen in the first DRAW cycle;
  // cyc is the strobe cycle relative to the trigger edge (DRAW = 1).
  function automatic exp_t predict(input logic [15:0] l0, input int mode, input int salt);
    exp_t        e;
    logic [15:0] l = l0;
    int          att = 0;
    int          t = 1;
    e.x = 5'd4; e.y = 4'd4; e.cyc = 0;
    for (int g = 0; g < 1000; g++) begin
      if (!in_range(l)) begin
        att++;
        if (att >= 64) begin e.cyc = t + 1; return e; end
        t++;
        l = step16(l);
      end else if (!blocked_fn(l[4:0], l[8:5], mode, salt)) begin
        e.x = l[4:0]; e.y = l[8:5]; e.cyc = t + 3;
        return e;
      end else begin
        att++;
        if (att >= 64) begin e.cyc = t + 3; return e; end
        t += 3;
        l = step16(step16(step16(l)));
      end
    end
    return e;
  endfunction

  assign cellBlocked = blocked_fn(queryX, queryY, cur_mode, cur_salt);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_lfsr <= SEED;
    else         m_lfsr <= step16(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  // Monitor: every strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (queryX > 5'd19 || queryY > 4'd14) bad_query++;
    if (resetN && randomRise) begin
      if (exp_q.size() == 0) begin
        check("strobe_expected", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_x", int'(outRandomX), int'(e.x));
        check("strobe_y", int'(outRandomY), int'(e.y));
        check("strobe_cycle", cyc + 1, e.cyc);
        check("strobe_x_on_grid", int'(outRandomX < 5'd20), 1);
        check("strobe_y_on_grid", int'(outRandomY < 4'd15), 1);
      end
    end
  end

  task automatic push_pred(input logic [15:0] l);
    exp_t e;
    e = predict(l, cur_mode, cur_salt);
    e.cyc += cyc;
    exp_q.push_back(e);
  endtask

  // Pulse newRandom; optionally wait for an in-range first candidate.
  task automatic trigger_req(input bit need_inrange, input bit push_exp,
                             input int mode, input int salt, output logic [15:0] dl);
    int guard = 0;
    @(negedge clk);
    cur_mode = mode;
    cur_salt = salt;
    if (need_inrange)
      while (!in_range(step16(m_lfsr)) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    newRandom = 1'b1;
    @(posedge clk);
    #1;
    newRandom = 1'b0;
    dl = m_lfsr;
    if (push_exp) push_pred(m_lfsr);
  endtask

  task automatic pulse_sec(input bit push_exp, input bit with_req);
    @(negedge clk);
    one_sec   = 1'b1;
    newRandom = with_req;
    @(posedge clk);
    #1;
    one_sec   = 1'b0;
    newRandom = 1'b0;
    if (push_exp) push_pred(m_lfsr);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("search_done_in_budget", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    resetN    = 1'b0;
    spawnEn   = 1'b0;
    newRandom = 1'b0;
    one_sec   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_queryX", int'(queryX), 4);
    check("rst_queryY", int'(queryY), 4);
    check("rst_outX", int'(outRandomX), 4);
    check("rst_outY", int'(outRandomY), 4);
    check("rst_randomRise", int'(randomRise), 0);
    check("rst_busy", int'(busy), 0);

    // Spawn period: one strobe after the 10th one_sec pulse only.
    resetN  = 1'b1;
    spawnEn = 1'b1;
    for (int i = 0; i < 9; i++) pulse_sec(1'b0, 1'b0);
    check("busy_before_period", int'(busy), 0);
    pulse_sec(1'b1, 1'b0);
    wait_done(300);

    // Request latency with in-range first candidates.
    for (int i = 0; i < 4; i++) begin
      trigger_req(1'b1, 1'b1, 0, 0, draw_l);
      wait_done(50);
    end

    // Every cell blocked: fallback after exhausting attempts.
    trigger_req(1'b0, 1'b1, 1, 0, draw_l);
    wait_done(400);

    // newRandom while busy is ignored.
    trigger_req(1'b1, 1'b1, 0, 0, draw_l);
    @(negedge clk);
    newRandom = 1'b1;
    @(negedge clk);
    newRandom = 1'b0;
    wait_done(50);
    repeat (8) @(negedge clk);

    // Period expiry coinciding with newRandom runs one search.
    for (int i = 0; i < 9; i++) pulse_sec(1'b0, 1'b0);
    pulse_sec(1'b1, 1'b1);
    wait_done(300);
    repeat (8) @(negedge clk);

    // Disabled: triggers ignored.
    spawnEn = 1'b0;
    pulse_sec(1'b0, 1'b1);
    check("disabled_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    spawnEn = 1'b1;

    // Abort during LOOKUP: idle next clock, no strobe.
    trigger_req(1'b1, 1'b0, 0, 0, draw_l);
    @(posedge clk);
    #1;
    check("abort_busy_in_lookup", int'(busy), 1);
    check("abort_queryX", int'(queryX), int'(draw_l[4:0]));
    check("abort_queryY", int'(queryY), int'(draw_l[8:5]));
    @(negedge clk);
    spawnEn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_after", int'(busy), 0);
    repeat (6) @(negedge clk);
    spawnEn = 1'b1;

    // Range sweep with a varying occupancy pattern.
    for (int i = 0; i < 1000; i++) begin
      trigger_req(1'b0, 1'b1, 2, i, draw_l);
      wait_done(400);
    end

    // Reset during CHECK: asynchronous return to reset values.
    trigger_req(1'b1, 1'b0, 0, 0, draw_l);
    @(posedge clk);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_queryX", int'(queryX), 4);
    check("midrst_queryY", int'(queryY), 4);
    check("midrst_outX", int'(outRandomX), 4);
    check("midrst_outY", int'(outRandomY), 4);
    check("midrst_randomRise", int'(randomRise), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // First searches after reset follow an LFSR restarted from SEED.
    trigger_req(1'b0, 1'b1, 0, 0, draw_l);
    wait_done(300);
    trigger_req(1'b1, 1'b1, 2, 7, draw_l);
    wait_done(400);

    check("query_never_off_grid", bad_query, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
